program_counter: RTL and testbench

- Architectural program-counter register for the 16-bit processor; sits at the head of the fetch stage.
- Each clock it loads the next-PC value chosen upstream by the next-PC mux (sequential, branch or jump) and presents it as the instruction-memory address.
- Also provides a sequential-increment output, so the upstream mux needs no separate adder.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/program_counter.sv | 33 +++
 tb/tb_program_counter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Fetch-stage PC width and reset vector.
package cpu_pkg;

  localparam int PC_WIDTH = 10;

  localparam logic [PC_WIDTH-1:0]
    PC_RESET_VALUE = '0;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/program_counter.sv
// Architectural PC register at the head of fetch.
// Loads next_pc each edge; offers pc + 1 for the mux.
module program_counter #(
  parameter int PC_WIDTH = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VALUE =
    cpu_pkg::PC_RESET_VALUE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] next_pc,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus_one,
  output logic                pc_valid
);

  localparam logic [PC_WIDTH-1:0] ONE =
    {{(PC_WIDTH-1){1'b0}}, 1'b1};

  // PC load with synchronous reset; valid once out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_VALUE;
      pc_valid <= 1'b0;
    end else begin
      pc       <= next_pc;
      pc_valid <= 1'b1;
    end
  end

  // Sequential increment, wraps silently at the top
  assign pc_plus_one = pc + ONE;

endmodule

// File: tb/tb_program_counter.sv
// Randomized scoreboard bench for program_counter.
// Two instances: default reset vector and 10'h100.
module tb_program_counter;
  import cpu_pkg::*;

  localparam int W = PC_WIDTH;
  localparam int MOD = 1 << W;

  typedef struct {
    int   id;
    pc_t  pc;
    pc_t  p1;
    logic v;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  pc_t  next_pc = '0;
  pc_t  pc0, p10, pc1, p11;
  logic v0, v1;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  int rv[2];
  int mpc[2];

  always #5 clk = ~clk;

  program_counter u0 (
    .clk(clk), .reset(reset),
    .next_pc(next_pc), .pc(pc0),
    .pc_plus_one(p10), .pc_valid(v0)
  );

  program_counter #(
    .RESET_VALUE(10'h100)
  ) u1 (
    .clk(clk), .reset(reset),
    .next_pc(next_pc), .pc(pc1),
    .pc_plus_one(p11), .pc_valid(v1)
  );

  // Reference: what pc must hold after an edge
  task automatic step(input logic r,
                      input int n);
    exp_t e;
    @(negedge clk);
    reset = r;
    next_pc = pc_t'(n);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      mpc[i] = r ? rv[i] : (n % MOD);
      e.id = i;
      e.pc = pc_t'(mpc[i]);
      e.p1 = pc_t'((mpc[i] + 1) % MOD);
      e.v  = !r;
      q.push_back(e);
    end
  endtask

  task automatic chk(input string nm,
                     input int a,
                     input int x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, a, x);
    end
  endtask

  // Monitor: compare each queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (e.id == 0 &&
            {pc0, p10, v0} !== {e.pc, e.p1, e.v}) begin
          errors++;
          $display("FAIL u0 got pc=%h p1=%h v=%b want pc=%h p1=%h v=%b",
                   pc0, p10, v0, e.pc, e.p1, e.v);
        end
        if (e.id == 1 &&
            {pc1, p11, v1} !== {e.pc, e.p1, e.v}) begin
          errors++;
          $display("FAIL u1 got pc=%h p1=%h v=%b want pc=%h p1=%h v=%b",
                   pc1, p11, v1, e.pc, e.p1, e.v);
        end
      end
    end
  end

  initial begin
    int n;
    logic r;
    rv[0] = 0;
    rv[1] = 'h100;
    // directed plan
    step(1'b1, 0);
    step(1'b0, 0);
    step(1'b0, 10);
    // next_pc changes mid-cycle: pc must hold
    @(negedge clk);
    next_pc = pc_t'(15);
    #2;
    chk("hold_mid", int'(pc0), mpc[0]);
    step(1'b0, 15);
    step(1'b0, 1);
    step(1'b0, 5);
    step(1'b0, 15);
    step(1'b1, 15);
    step(1'b0, 1);
    step(1'b0, 'h3FF);
    step(1'b0, (mpc[0] + 1) % MOD);
    step(1'b1, 'h2AA);
    step(1'b0, 'h2AA);
    // reset pulsed between edges: no effect
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("glitch_pc", int'(pc1), mpc[1]);
    chk("glitch_v", int'(v1), 1);
    // random phase
    for (int k = 0; k < 300; k++) begin
      r = ($urandom_range(15) == 0);
      case ($urandom_range(7))
        0: n = 'h3FF;
        1: n = 0;
        2: n = 'h100;
        default: n = $urandom_range(MOD - 1);
      endcase
      step(r, n);
    end
    @(posedge clk);
    #2;
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
